// File: rtl/ppu_bus_pkg.sv
// Shared types for the PPU video-memory bus: four-phase cycle states and requester IDs.
package ppu_bus_pkg;
   localparam int VRAM_AW = 14;

   typedef enum logic [2:0] {IDLE, ALE, HOLD, STROBE, CAPTURE} bus_state_t;
   typedef enum logic [1:0] {REQ_NONE, REQ_BG, REQ_SPR, REQ_CPU} req_id_t;
endpackage

// File: rtl/vram_cycle_sequencer.sv
// Four-phase VRAM bus engine (ALE, HOLD, STROBE, CAPTURE) with registered pin drivers.
module vram_cycle_sequencer
   import ppu_bus_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               start_i,
   input  logic [VRAM_AW-1:0] addr_i,
   input  logic               write_i,
   input  logic [7:0]         wdata_i,
   output logic               ready_o,
   output logic               capture_o,
   output logic [7:0]         rdata_o,
   output logic               busy_o,
   output logic [VRAM_AW-1:0] vRamAddressOut,
   output logic [7:0]         vRamDataOut,
   output logic               vRamDataDrive,
   input  logic [7:0]         vRamDataIn,
   output logic               addressLatchEnable,
   output logic               vRamRead,
   output logic               vRamWrite
);
   bus_state_t         state_q, state_d;
   logic [VRAM_AW-1:0] addr_q, addr_d;
   logic               wr_q, wr_d;
   logic [7:0]         wdata_q, wdata_d;
   logic               strobe_d;
   logic               ale_q, rd_n_q, wr_n_q, drive_q, busy_q;
   logic [7:0]         dout_q, rdata_q;

   assign ready_o   = (state_q == IDLE) || (state_q == CAPTURE);
   assign capture_o = (state_q == CAPTURE) && !wr_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE, CAPTURE: state_d = start_i ? ALE : IDLE;
         ALE:           state_d = HOLD;
         HOLD:          state_d = STROBE;
         STROBE:        state_d = CAPTURE;
         default:       state_d = IDLE;
      endcase
      if (start_i && ready_o) begin
         addr_d  = addr_i;
         wr_d    = write_i;
         wdata_d = wdata_i;
      end
   end

   // Pins are registered from the next state so they line up with the state they describe.
   assign strobe_d = (state_d == STROBE) || (state_d == CAPTURE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         ale_q   <= 1'b0;
         rd_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         drive_q <= 1'b0;
         dout_q  <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         ale_q   <= (state_d == ALE);
         rd_n_q  <= !(strobe_d && !wr_d);
         wr_n_q  <= !(strobe_d && wr_d);
         drive_q <= strobe_d && wr_d;
         if (strobe_d && wr_d) dout_q <= wdata_d;
         if (capture_o) rdata_q <= vRamDataIn;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign rdata_o            = rdata_q;
   assign busy_o             = busy_q;
   assign vRamAddressOut     = addr_q;
   assign vRamDataOut        = dout_q;
   assign vRamDataDrive      = drive_q;
   assign addressLatchEnable = ale_q;
   assign vRamRead           = rd_n_q;
   assign vRamWrite          = wr_n_q;
endmodule

// File: rtl/vram_bus_arbiter.sv
// Shares the VRAM bus between bg, sprite and CPU requesters with a CPU anti-starvation override.
module vram_bus_arbiter
   import ppu_bus_pkg::*;
#(
   parameter int CPU_STARVE_LIMIT = 8
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               bgReq,
   input  logic               sprReq,
   input  logic               cpuReq,
   input  logic [VRAM_AW-1:0] bgAddr,
   input  logic [VRAM_AW-1:0] sprAddr,
   input  logic [VRAM_AW-1:0] cpuAddr,
   input  logic               cpuWrite,
   input  logic [7:0]         cpuWData,
   output logic               bgAck,
   output logic               sprAck,
   output logic               cpuAck,
   output logic               bgValid,
   output logic               sprValid,
   output logic               cpuValid,
   output logic [7:0]         rdata,
   output logic               busy,
   output logic [VRAM_AW-1:0] vRamAddressOut,
   output logic [7:0]         vRamDataOut,
   output logic               vRamDataDrive,
   input  logic [7:0]         vRamDataIn,
   output logic               addressLatchEnable,
   output logic               vRamRead,
   output logic               vRamWrite
);
   localparam int SW = $clog2(CPU_STARVE_LIMIT + 1);

   logic [SW-1:0]      starve_q, starve_d;
   req_id_t            owner_q, owner_d, gnt;
   logic               start, ready, capture;
   logic [VRAM_AW-1:0] seq_addr;
   logic [2:0]         ack_q, valid_q;

   always_comb begin
      gnt = REQ_NONE;
      if (cpuReq && starve_q == SW'(CPU_STARVE_LIMIT)) gnt = REQ_CPU;
      else if (bgReq)                                   gnt = REQ_BG;
      else if (sprReq)                                  gnt = REQ_SPR;
      else if (cpuReq)                                  gnt = REQ_CPU;
      if (!ready) gnt = REQ_NONE;
   end

   assign start = (gnt != REQ_NONE);

   always_comb begin
      starve_d = starve_q;
      owner_d  = owner_q;
      if (!cpuReq)                                             starve_d = '0;
      else if (gnt == REQ_CPU)                                 starve_d = '0;
      else if (start && starve_q != SW'(CPU_STARVE_LIMIT))     starve_d = starve_q + 1'b1;
      if (start) owner_d = gnt;
      case (gnt)
         REQ_SPR: seq_addr = sprAddr;
         REQ_CPU: seq_addr = cpuAddr;
         default: seq_addr = bgAddr;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_q <= '0;
         owner_q  <= REQ_NONE;
         ack_q    <= '0;
         valid_q  <= '0;
      end else begin
         starve_q <= starve_d;
         owner_q  <= owner_d;
         ack_q    <= {gnt == REQ_CPU, gnt == REQ_SPR, gnt == REQ_BG};
         // Route by the owner finishing now, not the one being granted at this same edge.
         valid_q  <= {capture && owner_q == REQ_CPU,
                      capture && owner_q == REQ_SPR,
                      capture && owner_q == REQ_BG};
      end
   end

   assign {cpuAck, sprAck, bgAck}       = ack_q;
   assign {cpuValid, sprValid, bgValid} = valid_q;

   vram_cycle_sequencer u_seq (
      .clock              (clock),
      .reset              (reset),
      .start_i            (start),
      .addr_i             (seq_addr),
      .write_i            (gnt == REQ_CPU && cpuWrite),
      .wdata_i            (cpuWData),
      .ready_o            (ready),
      .capture_o          (capture),
      .rdata_o            (rdata),
      .busy_o             (busy),
      .vRamAddressOut     (vRamAddressOut),
      .vRamDataOut        (vRamDataOut),
      .vRamDataDrive      (vRamDataDrive),
      .vRamDataIn         (vRamDataIn),
      .addressLatchEnable (addressLatchEnable),
      .vRamRead           (vRamRead),
      .vRamWrite          (vRamWrite)
   );
endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Randomized bench for vram_bus_arbiter against a phase-count transaction model.
module tb_vram_bus_arbiter;
   localparam int LIMIT = 8;

   logic        clock = 1'b0, reset = 1'b1;
   logic        bgReq = 0, sprReq = 0, cpuReq = 0, cpuWrite = 0;
   logic [13:0] bgAddr = 0, sprAddr = 0, cpuAddr = 0;
   logic [7:0]  cpuWData = 0, vRamDataIn = 0;
   logic        bgAck, sprAck, cpuAck, bgValid, sprValid, cpuValid, busy;
   logic [7:0]  rdata, vRamDataOut;
   logic [13:0] vRamAddressOut;
   logic        vRamDataDrive, addressLatchEnable, vRamRead, vRamWrite;

   vram_bus_arbiter #(.CPU_STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset(reset),
      .bgReq(bgReq), .sprReq(sprReq), .cpuReq(cpuReq),
      .bgAddr(bgAddr), .sprAddr(sprAddr), .cpuAddr(cpuAddr),
      .cpuWrite(cpuWrite), .cpuWData(cpuWData),
      .bgAck(bgAck), .sprAck(sprAck), .cpuAck(cpuAck),
      .bgValid(bgValid), .sprValid(sprValid), .cpuValid(cpuValid),
      .rdata(rdata), .busy(busy),
      .vRamAddressOut(vRamAddressOut), .vRamDataOut(vRamDataOut),
      .vRamDataDrive(vRamDataDrive), .vRamDataIn(vRamDataIn),
      .addressLatchEnable(addressLatchEnable),
      .vRamRead(vRamRead), .vRamWrite(vRamWrite)
   );

   always #5 clock = ~clock;

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: phase = cycles since grant (1..4), 0 when the bus is idle.
   int         phase = 0, owner = 0, starve = 0;
   logic [13:0] cur_addr = 0;
   logic        cur_wr = 0;
   logic [7:0]  cur_wd = 0, m_rdata = 0;
   logic [2:0]  m_ack = 0, m_valid = 0;
   bit          drop_on_ack = 0, rnd_din = 1;

   task automatic model_step();
      logic [2:0] rq;
      int w;
      m_ack = 0;
      m_valid = 0;
      if (reset) begin
         phase = 0; starve = 0; cur_addr = 0; cur_wr = 0; m_rdata = 0;
         return;
      end
      if (phase == 4 && !cur_wr) begin
         m_rdata = vRamDataIn;
         m_valid[owner] = 1'b1;
      end
      if (phase == 0 || phase == 4) begin
         rq = {cpuReq, sprReq, bgReq};
         w = -1;
         if (cpuReq && starve == LIMIT) w = 2;
         else for (int i = 0; i < 3; i++) if (rq[i] && w < 0) w = i;
         if (w == 2) starve = 0;
         else if (w >= 0 && cpuReq && starve < LIMIT) starve++;
         if (w >= 0) begin
            phase    = 1;
            owner    = w;
            cur_addr = (w == 0) ? bgAddr : (w == 1) ? sprAddr : cpuAddr;
            cur_wr   = (w == 2) && cpuWrite;
            cur_wd   = cpuWData;
            m_ack[w] = 1'b1;
         end else phase = 0;
      end else phase++;
      if (!cpuReq) starve = 0;
   endtask

   task automatic check_outs();
      chk("ale",   addressLatchEnable, phase == 1);
      chk("rd_n",  vRamRead,  !(phase >= 3 && !cur_wr));
      chk("wr_n",  vRamWrite, !(phase >= 3 && cur_wr));
      chk("drive", vRamDataDrive, phase >= 3 && cur_wr);
      if (phase >= 3 && cur_wr) chk("dout", vRamDataOut, cur_wd);
      chk("addr",  vRamAddressOut, cur_addr);
      chk("busy",  busy, phase != 0);
      chk("ack",   {cpuAck, sprAck, bgAck}, m_ack);
      chk("valid", {cpuValid, sprValid, bgValid}, m_valid);
      chk("rdata", rdata, m_rdata);
   endtask

   task automatic cyc();
      @(posedge clock);
      model_step();
      @(negedge clock);
      check_outs();
      if (drop_on_ack) begin
         if (m_ack[0]) bgReq = 0;
         if (m_ack[1]) sprReq = 0;
         if (m_ack[2]) cpuReq = 0;
      end
      if (rnd_din) vRamDataIn = 8'($urandom);
   endtask

   int  nbg;
   bit  won;

   initial begin
      // reset state
      reset = 1;
      repeat (2) cyc();
      chk("rst_dout", vRamDataOut, 8'h00);
      reset = 0;

      // single bg read
      drop_on_ack = 1; rnd_din = 0; vRamDataIn = 8'hA7;
      bgAddr = 14'h2345; bgReq = 1;
      repeat (8) cyc();
      chk("bg_rdata", rdata, 8'hA7);
      rnd_din = 1;

      // cpu write
      cpuAddr = 14'h3F10; cpuWData = 8'h1D; cpuWrite = 1; cpuReq = 1;
      repeat (8) cyc();
      cpuWrite = 0;

      // simultaneous requests
      bgAddr = 14'h0100; sprAddr = 14'h1200; cpuAddr = 14'h2300;
      bgReq = 1; sprReq = 1; cpuReq = 1;
      repeat (16) cyc();

      // bg held with cpu pending: cpu must win after LIMIT bg grants
      drop_on_ack = 0; bgReq = 1; cpuReq = 1; bgAddr = 14'h0042; cpuAddr = 14'h0777;
      nbg = 0; won = 0;
      for (int c = 0; c < 60 && !won; c++) begin
         cyc();
         if (cpuAck) won = 1;
         else if (bgAck) nbg++;
      end
      chk("cpu_won", won, 1);
      chk("starve_gnts", nbg, LIMIT);
      cpuReq = 0;
      repeat (6) cyc();
      bgReq = 0;
      repeat (6) cyc();

      // reset during STROBE of a read
      drop_on_ack = 1; bgAddr = 14'h1ABC; bgReq = 1;
      for (int c = 0; c < 10 && phase != 3; c++) cyc();
      chk("reached_strobe", phase, 3);
      reset = 1;
      cyc();
      chk("rst_rd_release", vRamRead, 1'b1);
      reset = 0;
      bgAddr = 14'h0ABC; bgReq = 1;
      repeat (8) cyc();

      // random traffic with occasional reset
      drop_on_ack = 0;
      for (int c = 0; c < 3000; c++) begin
         if (m_ack[0] || !bgReq) begin
            bgReq = ($urandom_range(2) == 0); bgAddr = 14'($urandom);
         end else if ($urandom_range(19) == 0) bgReq = 0;
         if (m_ack[1] || !sprReq) begin
            sprReq = ($urandom_range(2) == 0); sprAddr = 14'($urandom);
         end else if ($urandom_range(19) == 0) sprReq = 0;
         if (m_ack[2] || !cpuReq) begin
            cpuReq = ($urandom_range(1) == 0); cpuAddr = 14'($urandom);
            cpuWrite = 1'($urandom); cpuWData = 8'($urandom);
         end else if ($urandom_range(19) == 0) cpuReq = 0;
         reset = ($urandom_range(299) == 0);
         cyc();
      end
      reset = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
